// File: rtl/jtag_gpif_shifter.sv
// JTAG shift engine: packed GPIF nibble commands drive TCK/TMS/TDI, TDO packed into result words.
// Build option JTAG_TDO_SYNC_EN: 2-flop tdo synchroniser, capture on last clk of TCK high.
module jtag_gpif_shifter #(
  parameter int DATA_W  = 8,
  parameter int TCK_DIV = 2,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_bits,
  input  logic              flush,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int NIB = DATA_W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int DW  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic              en_q;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_nx;
  logic [IW-1:0]     idx_q;
  logic [DW-1:0]     div_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] cap_ins;
  logic [CNT_W-1:0]  cnt_q;
  logic              tck_q;
  logic              tms_q;
  logic              tdi_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  out_bits_q;

  logic nib_v;
  logic nib_c;
  logic last;
  logic div_end;
  logic out_free;
  logic stall;
  logic accept;
  logic rise;
  logic fall;
  logic adv;
  logic cap_now;
  logic flush_now;
  logic tbit;

  assign nib_v    = sh_q[3];
  assign nib_c    = sh_q[2];
  assign last     = (idx_q == IW'(NIB - 1));
  assign div_end  = (div_q == DW'(TCK_DIV - 1));
  assign out_free = !out_valid_q || out_ready;
  assign stall    = nib_c && !out_free;
  assign accept   = in_valid && in_ready;
  assign sh_nx    = sh_q >> 4;
  assign cap_ins  = cap_q | (DATA_W'(tbit) << cnt_q);

`ifdef JTAG_TDO_SYNC_EN
  logic tdo_s1;
  logic tdo_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdo_s1 <= 1'b0;
      tdo_s2 <= 1'b0;
    end else begin
      tdo_s1 <= tdo;
      tdo_s2 <= tdo_s1;
    end
  end

  assign tbit    = tdo_s2;
  assign cap_now = fall && nib_c;
`else
  assign tbit    = tdo;
  assign cap_now = rise && nib_c;
`endif

  always_comb begin
    state_d   = state_q;
    rise      = 1'b0;
    fall      = 1'b0;
    adv       = 1'b0;
    flush_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q)
          state_d = LOAD;
        else if (flush && cnt_q != '0)
          state_d = FLUSH;
      end
      LOAD: state_d = LOW;
      LOW: begin
        if (!nib_v) begin
          adv = 1'b1;
          if (last)
            state_d = hold_full_q ? LOAD : IDLE;
        end else if (div_end && !stall) begin
          rise    = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (div_end) begin
          fall = 1'b1;
          adv  = 1'b1;
          if (last)
            state_d = hold_full_q ? LOAD : IDLE;
          else
            state_d = LOW;
        end
      end
      FLUSH: begin
        if (out_free) begin
          flush_now = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      en_q        <= 1'b0;
      sh_q        <= '0;
      idx_q       <= '0;
      div_q       <= '0;
      cap_q       <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;

      if (accept) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (state_q == LOAD) begin
        hold_full_q <= 1'b0;
      end

      // tms/tdi only move while tck is low: at load or at the falling edge
      if (state_q == LOAD) begin
        sh_q  <= hold_q;
        idx_q <= '0;
        if (hold_q[3]) begin
          tms_q <= hold_q[0];
          tdi_q <= hold_q[1];
        end
      end else if (adv) begin
        sh_q  <= sh_nx;
        idx_q <= idx_q + IW'(1);
        if (!last && sh_nx[3]) begin
          tms_q <= sh_nx[0];
          tdi_q <= sh_nx[1];
        end
      end

      if (state_q == HIGH) begin
        div_q <= div_end ? '0 : div_q + DW'(1);
      end else if (state_q == LOW && nib_v) begin
        if (!div_end)
          div_q <= div_q + DW'(1);
        else if (!stall)
          div_q <= '0;
      end else begin
        div_q <= '0;
      end

      if (rise)
        tck_q <= 1'b1;
      else if (fall)
        tck_q <= 1'b0;

      if (out_valid_q && out_ready)
        out_valid_q <= 1'b0;

      if (cap_now) begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          out_data_q  <= cap_ins;
          out_bits_q  <= CNT_W'(DATA_W);
          out_valid_q <= 1'b1;
          cap_q       <= '0;
          cnt_q       <= '0;
        end else begin
          cap_q <= cap_ins;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (flush_now) begin
        out_data_q  <= cap_q;
        out_bits_q  <= cnt_q;
        out_valid_q <= 1'b1;
        cap_q       <= '0;
        cnt_q       <= '0;
      end
    end
  end

  assign in_ready  = en_q && !hold_full_q;
  assign busy      = (state_q != IDLE) || hold_full_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_gpif_shifter.sv
// Directed bench for jtag_gpif_shifter (DATA_W=8, TCK_DIV=2).
// Monitors record TCK rises and consumed result words.
module tb_jtag_gpif_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] out_bits;
  logic       flush = 1'b0;
  logic       busy;
  logic       tck;
  logic       tms;
  logic       tdi;
  logic       tdo;

  always #5 clk = ~clk;

  jtag_gpif_shifter #(
    .DATA_W (8),
    .TCK_DIV(2),
    .CNT_W  (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits (out_bits),
    .flush    (flush),
    .busy     (busy),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int nr = 0;
  int base = 0;
  int nw = 0;
  logic tck_prev = 1'b0;
  logic rtms[256];
  logic rtdi[256];
  int   rcyc[256];
  logic [63:0] tdo_pat = '0;
  logic [7:0]  last_data = '0;
  logic [5:0]  last_bits = '0;

  assign tdo = tdo_pat[6'(nr - base)];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (tck && !tck_prev) begin
      rtms[nr & 255] = tms;
      rtdi[nr & 255] = tdi;
      rcyc[nr & 255] = cyc;
      nr++;
    end
    tck_prev = tck;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      nw++;
      last_data = out_data;
      last_bits = out_bits;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tck) && n < 500) begin
      tick();
      n++;
    end
    chk("idle_to", busy, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(4);
  endtask

  int r0;
  int w0;
  int rel;
  int n;

  initial begin
    tick(3);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ob", out_bits, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rdy_up", in_ready, 1);

    r0 = nr;
    w0 = nw;
    send(8'h9B);
    wait_idle();
    chk("t1_pulses", nr - r0, 2);
    chk("t1_tms0", rtms[r0], 1);
    chk("t1_tms1", rtms[r0 + 1], 1);
    chk("t1_tdi0", rtdi[r0], 1);
    chk("t1_tdi1", rtdi[r0 + 1], 0);
    chk("t1_period", rcyc[r0 + 1] - rcyc[r0], 4);
    chk("t1_noout", nw - w0, 0);

    base = nr;
    tdo_pat = 64'hA5;
    r0 = nr;
    w0 = nw;
    repeat (4) send(8'hCC);
    wait_idle();
    chk("t2_pulses", nr - r0, 8);
    chk("t2_words", nw - w0, 1);
    chk("t2_data", last_data, 8'hA5);
    chk("t2_bits", last_bits, 8);
    chk("t2_tms", rtms[r0 + 3], 0);

    r0 = nr;
    send(8'h00);
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    chk("t3_rdy", in_ready, 1);
    n = 0;
    while (busy && n < 3) begin
      tick();
      n++;
    end
    chk("t3_busy", busy, 0);
    chk("t3_notck", nr - r0, 0);

    out_ready = 1'b0;
    base = nr;
    tdo_pat = '1;
    repeat (4) send(8'hCC);
    wait_idle();
    chk("t4_ov", out_valid, 1);
    chk("t4_od", out_data, 8'hFF);
    chk("t4_ob", out_bits, 8);
    w0 = nw;
    r0 = nr;
    send(8'h0C);
    tick(10);
    chk("t4_stall_tck", tck, 0);
    chk("t4_stall_nr", nr - r0, 0);
    chk("t4_stall_busy", busy, 1);
    rel = cyc;
    out_ready = 1'b1;
    wait_idle();
    chk("t4_words", nw - w0, 1);
    chk("t4_wdata", last_data, 8'hFF);
    chk("t4_pulses", nr - r0, 1);
    chk("t4_after", rcyc[r0] > rel, 1);
    chk("t4_ov_clr", out_valid, 0);
    w0 = nw;
    do_flush();
    chk("t4f_words", nw - w0, 1);
    chk("t4f_data", last_data, 8'h01);
    chk("t4f_bits", last_bits, 1);

    base = nr;
    tdo_pat = 64'h3;
    send(8'hCC);
    send(8'h0C);
    wait_idle();
    w0 = nw;
    do_flush();
    chk("t5_words", nw - w0, 1);
    chk("t5_data", last_data, 8'h03);
    chk("t5_bits", last_bits, 3);
    w0 = nw;
    do_flush();
    chk("t5_empty", nw - w0, 0);

    base = nr;
    tdo_pat = '1;
    w0 = nw;
    send(8'hCC);
    n = 0;
    while (!tck && n < 50) begin
      tick();
      n++;
    end
    chk("t6_high", tck, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_tck", tck, 0);
    chk("t6_tms", tms, 1);
    chk("t6_tdi", tdi, 0);
    chk("t6_rdy", in_ready, 0);
    chk("t6_ov", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ob", out_bits, 0);
    rst_n = 1'b1;
    r0 = nr;
    tick();
    chk("t6_rdy_up", in_ready, 1);
    tick(10);
    chk("t6_notck", nr - r0, 0);
    do_flush();
    chk("t6_lost", nw - w0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/jtag_gpif_shifter.md
Name: jtag_gpif_shifter

Overview:
- Parametrised JTAG shift engine for the Platform Cable USB CPLD, placed between the FX2 GPIF byte bus and the JTAG pins.
- Replaces direct pin wiring. Each GPIF word carries packed per-TCK-cycle commands (TMS, TDI, capture flag).
- The engine generates TCK at a programmable divided rate and packs captured TDO bits into words for return to the FX2.

Parameters:
- DATA_W, 8: width of GPIF command and result words. Must be a multiple of 4, range 4..32.
- TCK_DIV, 2: clk cycles per TCK half-period. Minimum 1; minimum 3 with JTAG_TDO_SYNC_EN.
- CNT_W, 6: width of out_bits. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset.
- in_data, input, DATA_W: command word.
- in_valid, input, 1: command word present.
- in_ready, output, 1: holding register empty; a word is accepted when in_valid && in_ready.
- out_data, output, DATA_W: captured TDO word, first-captured bit in bit 0.
- out_valid, output, 1: result word present.
- out_ready, input, 1: consumer accepts the result word.
- out_bits, output, CNT_W: number of valid bits in out_data (DATA_W, or fewer after a flush).
- flush, input, 1: request to emit a partial capture word.
- busy, output, 1: engine not IDLE, or holding register full.
- tck, output, 1: JTAG clock.
- tms, output, 1: JTAG mode select.
- tdi, output, 1: JTAG data in.
- tdo, input, 1: JTAG data out from the target.

Behaviour:
Reset (rst_n low at a clk edge) forces:
- tck=0, tms=1, tdi=0
- in_ready=0, out_valid=0, out_data=0, out_bits=0, busy=0
- All state returns to IDLE; the holding register, shift register and capture count are cleared.
- in_ready rises on the first clk edge after rst_n is high.
- Reset mid-shift abandons the word and drops any partial capture. No further TCK edge is produced.

Command word format:
- DATA_W/4 nibbles, executed nibble 0 (bits 3:0) first.
- Nibble bit0 = TMS, bit1 = TDI, bit2 = capture TDO, bit3 = valid.
- A nibble with bit3=0 is skipped in 0 TCK cycles and 1 clk.

Datapath:
- One-word holding register feeds the shift register. in_ready = holding register empty, so a new word can be accepted while the previous word is shifting.
- States: IDLE, LOAD, LOW, HIGH, FLUSH.

State transitions:
- IDLE: if holding register full, go to LOAD. Else, if flush and capture count > 0, go to FLUSH.
- LOAD (1 clk): move holding register to the shift register; nibble index = 0.
- Valid nibble in LOW:
  - tms/tdi are registered from the nibble and tck=0, held for TCK_DIV clks.
  - If the capture bit is set and the result word is full with out_valid=1 and out_ready=0, LOW is extended (stall) and tck stays 0.
  - At the end of LOW: tck=1 and enter HIGH.
- HIGH:
  - Lasts TCK_DIV clks.
  - Capture: tdo is sampled on the clk edge where tck goes 1, shifted into bit [count], and count is incremented.
  - When count reaches DATA_W: out_data is loaded, out_bits=DATA_W, out_valid=1, count=0.
  - At the end of HIGH: tck=0, then advance to the next nibble, or to LOAD/IDLE after the last nibble.
- TCK period is 2*TCK_DIV clks. Back-to-back nibbles produce a continuous TCK. tms/tdi change only when tck falls.
- FLUSH (1 clk): waits until out_valid=0. It then outputs the partial word with upper bits zero and out_bits = count, sets count=0 and returns to IDLE.
- flush while not IDLE is ignored until IDLE. flush with count=0 produces no word.

Handshake:
- out_valid is held until out_ready is seen. It clears on the clk edge where out_valid && out_ready.
- A new result word may be loaded on the same edge it is consumed.

Optional Feature:
JTAG_TDO_SYNC_EN
- Defined:
  - tdo passes through a 2-flop synchroniser.
  - The capture sample is taken from the synchronised value on the last clk of HIGH, not at the tck rise.
  - Requires TCK_DIV>=3. The TCK waveform is unchanged.
- Undefined:
  - tdo is sampled directly on the tck-rise edge.

Test Plan:
1. DATA_W=8, TCK_DIV=2; send 0x9B. Expect:
   - Two TCK pulses, period 4 clk.
   - tms=1 for both; tdi=1 on pulse 1, 0 on pulse 2.
   - No out_valid.
2. Send 0xCC four times with tdo driven 1,0,1,0,0,1,0,1 on successive rises. Expect exactly one out_valid with out_data=0xA5, out_bits=8.
3. Send 0x00. Expect no tck edge; in_ready re-asserts; busy returns to 0 within 3 clk.
4. Hold out_ready=0 with a full result pending, then send 0x0C. Expect:
   - tck held 0 while stalled.
   - The pulse begins only after out_ready=1 clears the word.
5. Capture 3 bits (1,1,0), then pulse flush in IDLE. Expect out_data=0x03, out_bits=3; count returns to 0.
6. Assert rst_n=0 mid-HIGH. Expect on the next edge: tck=0, tms=1, tdi=0, in_ready=0, out_valid=0; the partial capture is lost.
